// File: rtl/mem_pkg.sv
// Shared encodings for the data memory responder: access sizes, FSM states
// and a helper that turns a size code into a byte count.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam int unsigned CNT_W = 4;

  function automatic logic [3:0] size_bytes(input size_e sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Sign or zero extension of right-aligned load data according to access size.
module load_extend
  import mem_pkg::*;
(
  input  logic [63:0] i_raw,
  input  size_e       i_size,
  input  logic        i_unsigned,
  output logic [63:0] o_data
);

  logic w_sign_b;
  logic w_sign_h;
  logic w_sign_w;

  assign w_sign_b = ~i_unsigned & i_raw[7];
  assign w_sign_h = ~i_unsigned & i_raw[15];
  assign w_sign_w = ~i_unsigned & i_raw[31];

  // Doubleword loads pass straight through; the unsigned flag has no effect.
  always_comb begin
    o_data = i_raw;
    case (i_size)
      SZ_B:    o_data = {{56{w_sign_b}}, i_raw[7:0]};
      SZ_H:    o_data = {{48{w_sign_h}}, i_raw[15:0]};
      SZ_W:    o_data = {{32{w_sign_w}}, i_raw[31:0]};
      default: o_data = i_raw;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Byte-addressed data memory with a single outstanding request and a fixed
// request-to-response latency; loads are extended, bad accesses are flagged.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 512,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_write;
  logic             r_unsigned;
  logic [63:0]      r_addr;
  logic [63:0]      r_wdata;
  size_e            r_size;
  logic [63:0]      r_rdata;
  logic             r_err;
  logic [7:0]       r_mem [DEPTH_BYTES];

  logic        w_accept;
  logic        w_fire;
  logic [3:0]  w_nbytes;
  logic        w_misaligned;
  logic [64:0] w_end;
  logic        w_oob;
  logic        w_err;
  logic [63:0] w_raw;
  logic [63:0] w_ext;

  assign w_accept = (r_state == ST_IDLE) && req_valid;
  assign w_fire   = (r_state == ST_BUSY) && (r_cnt == '0);

  assign w_nbytes     = size_bytes(r_size);
  assign w_misaligned = |(r_addr[2:0] & (w_nbytes[2:0] - 3'd1));
  // One extra bit so addresses near the top of the 64-bit space cannot wrap.
  assign w_end        = {1'b0, r_addr} + {61'd0, w_nbytes};
  assign w_oob        = w_end > 65'(DEPTH_BYTES);
  assign w_err        = w_misaligned | w_oob;

  always_comb begin
    w_raw = '0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < w_nbytes) begin
        w_raw[8*k +: 8] = r_mem[r_addr[AW-1:0] + AW'(k)];
      end
    end
  end

  load_extend u_load_extend (
    .i_raw      (w_raw),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_ext)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_rdata   = r_rdata;
    resp_err     = r_err;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_next = ST_BUSY;
      end
      ST_BUSY: begin
        if (r_cnt == '0) w_state_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_write    <= 1'b0;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_size     <= SZ_B;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt      <= CNT_INIT;
        r_write    <= req_write;
        r_unsigned <= req_unsigned;
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
        r_size     <= size_e'(req_size);
      end else if ((r_state == ST_BUSY) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      // Response data is captured once and held until the initiator takes it.
      if (w_fire) begin
        r_err   <= w_err;
        r_rdata <= (w_err || r_write) ? 64'd0 : w_ext;
      end
    end
  end

  // Storage is deliberately left out of reset; a reset edge also blocks commit.
  always_ff @(posedge clk) begin
    if (reset && w_fire && r_write && !w_err) begin
      for (int k = 0; k < 8; k++) begin
        if (4'(k) < w_nbytes) begin
          r_mem[r_addr[AW-1:0] + AW'(k)] <= r_wdata[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: randomized traffic against a byte-array memory model,
// plus directed cases and latency checks on LATENCY=1 and LATENCY=4 copies.
module tb_data_mem_responder;

  localparam int DEPTH    = 512;
  localparam int MAIN_LAT = 2;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;

  logic        lv_req_valid [2];
  logic        lv_req_ready [2];
  logic        lv_write     [2];
  logic [63:0] lv_addr      [2];
  logic [63:0] lv_wdata     [2];
  logic [1:0]  lv_size      [2];
  logic        lv_resp_valid[2];
  logic [63:0] lv_rdata     [2];
  logic        lv_err       [2];

  int total = 0;
  int bad   = 0;
  bit chkEn = 0;

  // Model state: memory bytes plus the one outstanding request, if any.
  logic [7:0]  mdl [DEPTH];
  bit          mOutstanding = 0;
  int          mAge = 0;
  bit          mSawReset = 0;
  bit          mWrite, mUns;
  logic [63:0] mAddr, mWdata, mRd;
  logic [1:0]  mSize;
  bit          mErr;

  initial clk = 0;
  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(MAIN_LAT)) dut (
    .clk(clk), .reset(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_unsigned), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  data_mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(1)) dutL1 (
    .clk(clk), .reset(rst_n), .req_valid(lv_req_valid[0]), .req_ready(lv_req_ready[0]),
    .req_write(lv_write[0]), .req_addr(lv_addr[0]), .req_wdata(lv_wdata[0]),
    .req_size(lv_size[0]), .req_unsigned(1'b0), .resp_valid(lv_resp_valid[0]),
    .resp_ready(1'b1), .resp_rdata(lv_rdata[0]), .resp_err(lv_err[0])
  );

  data_mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(4)) dutL4 (
    .clk(clk), .reset(rst_n), .req_valid(lv_req_valid[1]), .req_ready(lv_req_ready[1]),
    .req_write(lv_write[1]), .req_addr(lv_addr[1]), .req_wdata(lv_wdata[1]),
    .req_size(lv_size[1]), .req_unsigned(1'b0), .resp_valid(lv_resp_valid[1]),
    .resp_ready(1'b1), .resp_rdata(lv_rdata[1]), .resp_err(lv_err[1])
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
    end
  endtask

  // Executes the modelled access: error rule, little-endian bytes, extension.
  function automatic void modelOp();
    int n;
    logic [63:0] raw;
    n = 1 << mSize;
    mErr = ((mAddr & 64'(n - 1)) != 0) || (mAddr > 64'(DEPTH - n));
    mRd = '0;
    if (!mErr) begin
      if (mWrite) begin
        for (int k = 0; k < n; k++) mdl[int'(mAddr) + k] = mWdata[8*k +: 8];
      end else begin
        raw = '0;
        for (int k = 0; k < n; k++) raw[8*k +: 8] = mdl[int'(mAddr) + k];
        if (n < 8 && !mUns && raw[8*n-1]) raw = raw | (~64'd0 << (8*n));
        mRd = raw;
      end
    end
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      mOutstanding = 0;
      mAge = 0;
      mSawReset = 1;
    end else begin
      mSawReset = 0;
      if (mOutstanding) begin
        if (mAge < MAIN_LAT) begin
          mAge++;
          if (mAge == MAIN_LAT) modelOp();
        end else if (resp_ready) begin
          mOutstanding = 0;
        end
      end else if (req_valid) begin
        mOutstanding = 1;
        mAge = 0;
        mWrite = req_write;
        mUns = req_unsigned;
        mAddr = req_addr;
        mWdata = req_wdata;
        mSize = req_size;
      end
    end
  end

  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("req_ready", 64'(req_ready), 64'(!mOutstanding));
      checkOutput("resp_valid", 64'(resp_valid), 64'(mOutstanding && mAge == MAIN_LAT));
      if (mOutstanding && mAge == MAIN_LAT) begin
        checkOutput("resp_rdata", resp_rdata, mRd);
        checkOutput("resp_err", 64'(resp_err), 64'(mErr));
      end
      if (mSawReset) begin
        checkOutput("reset_rdata", resp_rdata, 64'd0);
        checkOutput("reset_err", 64'(resp_err), 64'd0);
      end
    end
  end

  task automatic applyStimulus(input bit w, input logic [63:0] a, input logic [63:0] wd,
                               input logic [1:0] sz, input bit u, input int holdCyc,
                               output logic [63:0] rd, output bit er);
    int n;
    rd = '0;
    er = 0;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (req_ready !== 1'b1) begin
      checkOutput("ready_timeout", 64'(req_ready), 64'd1);
      return;
    end
    req_valid = 1; req_write = w; req_addr = a; req_wdata = wd;
    req_size = sz; req_unsigned = u; resp_ready = 0;
    @(posedge clk); #1;
    req_valid = 1'($urandom_range(0, 1));
    req_write = 1'($urandom_range(0, 1));
    req_addr = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    req_size = 2'($urandom_range(0, 3));
    n = 0;
    while (resp_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    if (resp_valid !== 1'b1) begin
      checkOutput("resp_timeout", 64'(resp_valid), 64'd1);
      req_valid = 0;
      return;
    end
    rd = resp_rdata;
    er = resp_err;
    repeat (holdCyc) begin @(posedge clk); #1; end
    checkOutput("hold_rdata", resp_rdata, rd);
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
    req_valid = 0;
  endtask

  task automatic latencyCheck(input int idx, input int expLat, input bit w,
                              input logic [63:0] a, input logic [63:0] wd,
                              input logic [1:0] sz, output logic [63:0] rd);
    int n;
    rd = '0;
    n = 0;
    while (lv_req_ready[idx] !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (lv_req_ready[idx] !== 1'b1) begin
      checkOutput("lat_ready_timeout", 64'(lv_req_ready[idx]), 64'd1);
      return;
    end
    lv_req_valid[idx] = 1; lv_write[idx] = w; lv_addr[idx] = a;
    lv_wdata[idx] = wd; lv_size[idx] = sz;
    @(posedge clk); #1;
    lv_req_valid[idx] = 0;
    n = 0;
    while (lv_resp_valid[idx] !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checkOutput($sformatf("latency_%0d", expLat), 64'(n), 64'(expLat));
    rd = lv_rdata[idx];
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] rd;
    bit er;
    int n;
    logic [63:0] a;
    logic [1:0] sz;

    rst_n = 0; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    req_size = 0; req_unsigned = 0; resp_ready = 0;
    for (int i = 0; i < 2; i++) begin
      lv_req_valid[i] = 0; lv_write[i] = 0; lv_addr[i] = 0; lv_wdata[i] = 0; lv_size[i] = 0;
    end

    repeat (3) @(posedge clk);
    #1 chkEn = 1;
    @(posedge clk); #1;
    checkOutput("reset_req_ready", 64'(req_ready), 64'd1);
    checkOutput("reset_resp_valid", 64'(resp_valid), 64'd0);
    rst_n = 1;

    // Fill storage so every later load has a defined model value.
    for (int i = 0; i < DEPTH / 8; i++)
      applyStimulus(1, 64'(8 * i), {$urandom, $urandom}, 2'b11, 0, 0, rd, er);

    applyStimulus(1, 64'd8, 64'h1122334455667788, 2'b11, 0, 0, rd, er);
    applyStimulus(0, 64'd8, 64'd0, 2'b00, 0, 0, rd, er);
    checkOutput("lb_8", rd, 64'hFFFFFFFFFFFFFF88);
    applyStimulus(0, 64'd8, 64'd0, 2'b00, 1, 0, rd, er);
    checkOutput("lbu_8", rd, 64'h0000000000000088);
    applyStimulus(0, 64'd14, 64'd0, 2'b01, 0, 0, rd, er);
    checkOutput("lh_14", rd, 64'h0000000000001122);

    applyStimulus(0, 64'd2, 64'd0, 2'b10, 0, 0, rd, er);
    checkOutput("lw_2_err", 64'(er), 64'd1);
    checkOutput("lw_2_rdata", rd, 64'd0);
    applyStimulus(1, 64'(DEPTH - 2), 64'd0, 2'b01, 0, 0, rd, er);
    applyStimulus(1, 64'(DEPTH - 2), 64'hFFFF_0000_BEEF, 2'b01, 0, 0, rd, er);
    applyStimulus(1, 64'(DEPTH - 2), 64'h1234_5678, 2'b10, 0, 0, rd, er);
    checkOutput("sw_top_err", 64'(er), 64'd1);
    applyStimulus(0, 64'(DEPTH - 2), 64'd0, 2'b01, 1, 0, rd, er);
    checkOutput("lhu_top_unchanged", rd, 64'h000000000000BEEF);

    applyStimulus(0, 64'd8, 64'd0, 2'b11, 1, 5, rd, er);
    checkOutput("ld_8_hold", rd, 64'h1122334455667788);

    applyStimulus(0, 64'(DEPTH - 8), 64'd0, 2'b11, 0, 1, rd, er);
    checkOutput("ld_last_ok", 64'(er), 64'd0);
    applyStimulus(0, 64'(DEPTH), 64'd0, 2'b11, 0, 0, rd, er);
    checkOutput("ld_depth_err", 64'(er), 64'd1);
    applyStimulus(0, 64'hFFFFFFFFFFFFFFF8, 64'd0, 2'b11, 0, 0, rd, er);
    checkOutput("ld_wrap_err", 64'(er), 64'd1);

    // A reset one edge after acceptance must swallow the pending store.
    applyStimulus(1, 64'd4, 64'h5C, 2'b00, 0, 0, rd, er);
    req_valid = 1; req_write = 1; req_addr = 64'd4; req_wdata = 64'hAB;
    req_size = 2'b00; req_unsigned = 0;
    @(posedge clk); #1;
    req_valid = 0;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    repeat (6) @(posedge clk);
    #1;
    applyStimulus(0, 64'd4, 64'd0, 2'b00, 1, 0, rd, er);
    checkOutput("lbu_4_after_abort", rd, 64'h000000000000005C);

    for (int t = 0; t < 200; t++) begin
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) a = {$urandom, $urandom};
      else a = 64'($urandom_range(0, DEPTH + 7));
      if ($urandom_range(0, 3) != 0) a = a & ~(64'(1 << sz) - 64'd1);
      applyStimulus(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, sz,
                    1'($urandom_range(0, 1)), $urandom_range(0, 3), rd, er);
    end

    latencyCheck(0, 1, 1, 64'd16, 64'hCAFEF00D12345678, 2'b11, rd);
    latencyCheck(0, 1, 0, 64'd16, 64'd0, 2'b10, rd);
    checkOutput("l1_lw_16", rd, 64'h0000000012345678);
    latencyCheck(1, 4, 1, 64'd16, 64'h00000000000080FF, 2'b01, rd);
    latencyCheck(1, 4, 0, 64'd16, 64'd0, 2'b01, rd);
    checkOutput("l4_lh_16", rd, 64'hFFFFFFFFFFFF80FF);

    n = 0;
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
